// File: rtl/bram_acc_ctrl_if.sv
// Request stream and dual-port BRAM bus of the accumulate controller.
// master: controller side (req_ready, port A/B drive); slave: source + BRAM.
interface bram_acc_ctrl_if #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 11
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_delta;
  logic                  en_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic                  en_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;

  modport master (
    input  req_valid, req_addr, req_delta, data_out_a,
    output req_ready, en_a, we_a, addr_a, data_in_a,
    output en_b, we_b, addr_b, data_in_b
  );

  modport slave (
    output req_valid, req_addr, req_delta, data_out_a,
    input  req_ready, en_a, we_a, addr_a, data_in_a,
    input  en_b, we_b, addr_b, data_in_b
  );
endinterface

// File: rtl/bram_acc_ctrl.sv
// Saturating read-modify-write accumulator in front of a dual-port BRAM.
// Ports: clk, rst (async high), bus (bram_acc_ctrl_if.master: request
// stream, read port A, write port B), busy, sat_flag (sticky), op_count.
// Macro BRAM_ACC_FORWARD_EN: S2/S3 forwarding and full throughput;
// undefined: same-address requests stall until the prior write lands.
module bram_acc_ctrl #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 11
) (
  input  logic        clk,
  input  logic        rst,
  bram_acc_ctrl_if.master bus,
  output logic        busy,
  output logic        sat_flag,
  output logic [31:0] op_count
);
  localparam logic [DATA_WIDTH-1:0] MAX_V =
    {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] MIN_V =
    {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic                  accept;
  logic                  s1_valid;
  logic [ADDR_WIDTH-1:0] s1_addr;
  logic [DATA_WIDTH-1:0] s1_delta;
  logic                  s2_valid;
  logic [ADDR_WIDTH-1:0] s2_addr;
  logic [DATA_WIDTH-1:0] s2_sum;
  logic [DATA_WIDTH-1:0] operand;
  logic [DATA_WIDTH:0]   wide_sum;
  logic                  ovf;
  logic [DATA_WIDTH-1:0] sat_sum;

`ifdef BRAM_ACC_FORWARD_EN
  logic                  s3_valid;
  logic [ADDR_WIDTH-1:0] s3_addr;
  logic [DATA_WIDTH-1:0] s3_sum;

  assign bus.req_ready = !rst;
`else
  // Hold off a request whose word is still being read or written.
  assign bus.req_ready = !rst
    && !(s1_valid && s1_addr == bus.req_addr)
    && !(s2_valid && s2_addr == bus.req_addr);
`endif

  assign accept        = bus.req_valid && bus.req_ready;
  assign bus.en_a      = accept;
  assign bus.we_a      = 1'b0;
  assign bus.addr_a    = accept ? bus.req_addr : '0;
  assign bus.data_in_a = '0;

  assign bus.en_b      = s2_valid;
  assign bus.we_b      = s2_valid;
  assign bus.addr_b    = s2_addr;
  assign bus.data_in_b = s2_sum;
  assign busy          = s1_valid || s2_valid;

  // Newest in-flight value wins: S2 is younger than S3.
  always_comb begin
    operand = bus.data_out_a;
`ifdef BRAM_ACC_FORWARD_EN
    if (s2_valid && s2_addr == s1_addr) begin
      operand = s2_sum;
    end else if (s3_valid && s3_addr == s1_addr) begin
      operand = s3_sum;
    end
`endif
  end

  // One extra bit: overflow shows as disagreement of the top two bits.
  always_comb begin
    wide_sum = {operand[DATA_WIDTH-1], operand}
             + {s1_delta[DATA_WIDTH-1], s1_delta};
    ovf      = wide_sum[DATA_WIDTH] ^ wide_sum[DATA_WIDTH-1];
    sat_sum  = wide_sum[DATA_WIDTH-1:0];
    if (ovf) begin
      sat_sum = wide_sum[DATA_WIDTH] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_delta <= '0;
      s2_valid <= 1'b0;
      s2_addr  <= '0;
      s2_sum   <= '0;
      sat_flag <= 1'b0;
      op_count <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_addr  <= bus.req_addr;
        s1_delta <= bus.req_delta;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_addr <= s1_addr;
        s2_sum  <= sat_sum;
        if (ovf) begin
          sat_flag <= 1'b1;
        end
      end
      if (s2_valid) begin
        op_count <= op_count + 32'd1;
      end
    end
  end

`ifdef BRAM_ACC_FORWARD_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_addr  <= '0;
      s3_sum   <= '0;
    end else begin
      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_addr <= s2_addr;
        s3_sum  <= s2_sum;
      end
    end
  end
`endif
endmodule
